// File: rtl/hangman_disp_pkg.sv
// Shared state encoding and ASCII constants for the Hangman LCD display path.
package hangman_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT,
        DUPL
    } disp_state_t;

    localparam logic [7:0] SPACE       = 8'h20;
    localparam logic [7:0] UNDERSCORE  = 8'h5F;
    localparam logic [7:0] UPPER_A     = 8'h41;
    localparam logic [7:0] UPPER_Z     = 8'h5A;
    localparam logic [7:0] LOWER_A     = 8'h61;
    localparam logic [7:0] LOWER_Z     = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

endpackage

// File: rtl/ascii_letter_norm.sv
// Folds lower-case ASCII letters to upper case and flags whether the input is a letter at all.
module ascii_letter_norm
    import hangman_disp_pkg::*;
(
    input  logic [7:0] char_in,
    output logic [7:0] char_out,
    output logic       is_letter
);

    logic is_upper;
    logic is_lower;

    always_comb begin
        is_upper  = (char_in >= UPPER_A) && (char_in <= UPPER_Z);
        is_lower  = (char_in >= LOWER_A) && (char_in <= LOWER_Z);
        is_letter = is_upper || is_lower;
        char_out  = is_lower ? (char_in - CASE_OFFSET) : char_in;
    end

endmodule

// File: rtl/hangman_display_ctrl.sv
// Guess-history display controller: validates letters, scans history for duplicates,
// appends new guesses (dropping the oldest when full) and drives two LCD row buffers.
module hangman_display_ctrl
    import hangman_disp_pkg::*;
#(
    parameter int         COLS  = 16,
    parameter int         SLOTS = 10,
    parameter logic [7:0] BLANK = UNDERSCORE
) (
    input  logic                         clk,
    input  logic                         nRst,
    input  logic                         valid,
    input  logic [7:0]                   letter,
    input  logic                         clear,
    output logic                         ready,
    output logic [8*COLS-1:0]            row1,
    output logic [8*COLS-1:0]            row2,
    output logic                         dup,
    output logic                         reject,
    output logic                         full,
    output logic [$clog2(SLOTS+1)-1:0]   count
);

    localparam int            CW       = $clog2(SLOTS + 1);
    localparam int            CENTER   = (COLS - 1) / 2;
    localparam logic [CW-1:0] SLOTS_CW = CW'(SLOTS);

    generate
        if (SLOTS < 1 || SLOTS > COLS) begin : g_bad_slots
            $error("hangman_display_ctrl: SLOTS must lie in 1..COLS");
        end
    endgenerate

    // Column 0 is the most-significant byte of a row.
    function automatic logic [8*COLS-1:0] history_row(input logic [SLOTS-1:0][7:0] s);
        history_row = {COLS{SPACE}};
        for (int i = 0; i < SLOTS; i++) begin
            history_row[8*(COLS-1-i) +: 8] = s[i];
        end
    endfunction

    function automatic logic [8*COLS-1:0] latest_row(input logic [7:0] c);
        latest_row = {COLS{SPACE}};
        latest_row[8*(COLS-1-CENTER) +: 8] = c;
    endfunction

    localparam logic [8*COLS-1:0] ROW2_RESET = history_row({SLOTS{BLANK}});

    disp_state_t              state;
    logic [7:0]               cur;
    logic [CW-1:0]            idx;
    logic [SLOTS-1:0][7:0]    slots;
    logic [SLOTS-1:0][7:0]    next_slots;
    logic [7:0]               slot_at_idx;
    logic [7:0]               norm_char;
    logic                     norm_is_letter;

    ascii_letter_norm u_norm (
        .char_in   (letter),
        .char_out  (norm_char),
        .is_letter (norm_is_letter)
    );

    assign ready = (state == IDLE);
    assign full  = (count == SLOTS_CW);

    always_comb begin
        slot_at_idx = BLANK;
        for (int i = 0; i < SLOTS; i++) begin
            if (idx == CW'(i)) begin
                slot_at_idx = slots[i];
            end
        end
    end

    // History after committing cur: append, or shift out the oldest when already full.
    always_comb begin
        next_slots = slots;
        if (full) begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                next_slots[i] = slots[i + 1];
            end
            next_slots[SLOTS-1] = cur;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (count == CW'(i)) begin
                    next_slots[i] = cur;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state  <= IDLE;
            cur    <= SPACE;
            idx    <= '0;
            slots  <= {SLOTS{BLANK}};
            count  <= '0;
            row1   <= {COLS{SPACE}};
            row2   <= ROW2_RESET;
            dup    <= 1'b0;
            reject <= 1'b0;
        end else if (clear) begin
            state  <= IDLE;
            cur    <= SPACE;
            idx    <= '0;
            slots  <= {SLOTS{BLANK}};
            count  <= '0;
            row1   <= {COLS{SPACE}};
            row2   <= ROW2_RESET;
            dup    <= 1'b0;
            reject <= 1'b0;
        end else begin
            dup    <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (norm_is_letter) begin
                            cur   <= norm_char;
                            idx   <= '0;
                            state <= SCAN;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (idx >= count) begin
                        state <= COMMIT;
                    end else if (slot_at_idx == cur) begin
                        state <= DUPL;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                COMMIT: begin
                    slots <= next_slots;
                    if (!full) begin
                        count <= count + CW'(1);
                    end
                    row1  <= latest_row(cur);
                    row2  <= history_row(next_slots);
                    state <= IDLE;
                end
                DUPL: begin
                    dup   <= 1'b1;
                    row1  <= latest_row(cur);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hangman_display_ctrl.sv
// Scoreboard bench for hangman_display_ctrl: a queue-based history model predicts each response.
module tb_hangman_display_ctrl;

    localparam int COLS   = 16;
    localparam int SLOTS  = 10;
    localparam int CW     = $clog2(SLOTS + 1);
    localparam int CENTER = (COLS - 1) / 2;
    localparam int RW     = 8 * COLS;

    logic          clk    = 1'b0;
    logic          nRst   = 1'b0;
    logic          valid  = 1'b0;
    logic          clear  = 1'b0;
    logic [7:0]    letter = 8'h00;
    logic          ready;
    logic          dup;
    logic          reject;
    logic          full;
    logic [RW-1:0] row1;
    logic [RW-1:0] row2;
    logic [CW-1:0] count;

    hangman_display_ctrl #(.COLS(COLS), .SLOTS(SLOTS), .BLANK(8'h5F)) dut (
        .clk    (clk),
        .nRst   (nRst),
        .valid  (valid),
        .letter (letter),
        .clear  (clear),
        .ready  (ready),
        .row1   (row1),
        .row2   (row2),
        .dup    (dup),
        .reject (reject),
        .full   (full),
        .count  (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_reject;
        bit            exp_dup;
        logic [RW-1:0] r1;
        logic [RW-1:0] r2;
        int            cnt;
        int            accept_edge;
        int            lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] hist[$];
    logic [7:0] shown;
    bit         shown_valid = 1'b0;
    int         n_compared   = 0;
    int         n_mismatched = 0;
    int         edge_cnt     = 0;
    bit         prev_ready   = 1'b1;
    bit         last_flush   = 1'b1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] want);
        n_compared++;
        if (act !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, act, want);
        end
    endtask

    // Reference model: history is a plain queue of upper-case letters, oldest first.
    function automatic logic [RW-1:0] model_row1();
        logic [RW-1:0] r;
        r = '0;
        for (int col = 0; col < COLS; col++) begin
            r[RW-1-8*col -: 8] = (shown_valid && col == CENTER) ? shown : 8'h20;
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] model_row2();
        logic [RW-1:0] r;
        logic [7:0]    b;
        r = '0;
        for (int col = 0; col < COLS; col++) begin
            if (col >= SLOTS)          b = 8'h20;
            else if (col < hist.size()) b = hist[col];
            else                       b = 8'h5F;
            r[RW-1-8*col -: 8] = b;
        end
        return r;
    endfunction

    task automatic resetModel();
        hist.delete();
        shown_valid = 1'b0;
        shown       = 8'h20;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, " row1"},   row1,           model_row1());
        checkOutput({tag, " row2"},   row2,           model_row2());
        checkOutput({tag, " count"},  RW'(count),     RW'(hist.size()));
        checkOutput({tag, " full"},   RW'(full),      RW'(hist.size() == SLOTS));
        checkOutput({tag, " ready"},  RW'(ready),     RW'(1));
        checkOutput({tag, " dup"},    RW'(dup),       RW'(0));
        checkOutput({tag, " reject"}, RW'(reject),    RW'(0));
    endtask

    // Driver phase is always #1 after a rising edge.
    task automatic waitReady();
        int n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL wait_ready: got ready=0 after %0d cycles, wanted 1", n);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ch);
        exp_t       e;
        logic [7:0] up;
        bit         is_letter;
        int         pos;
        waitReady();
        valid  = 1'b1;
        letter = ch;
        is_letter = (ch >= 8'h41 && ch <= 8'h5A) || (ch >= 8'h61 && ch <= 8'h7A);
        up        = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'd32 : ch;
        e.accept_edge = edge_cnt + 1;
        e.is_reject   = !is_letter;
        e.exp_dup     = 1'b0;
        e.lat         = 0;
        if (is_letter) begin
            pos = -1;
            foreach (hist[i]) if (pos < 0 && hist[i] == up) pos = i;
            if (pos >= 0) begin
                e.exp_dup = 1'b1;
                e.lat     = pos + 2;
            end else begin
                e.lat = hist.size() + 2;
                if (hist.size() == SLOTS) void'(hist.pop_front());
                hist.push_back(up);
            end
            shown       = up;
            shown_valid = 1'b1;
        end
        e.r1  = model_row1();
        e.r2  = model_row2();
        e.cnt = hist.size();
        exp_q.push_back(e);
        @(posedge clk); #1;
        valid  = 1'b0;
        letter = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d pending responses, wanted 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pops one expectation per reject pulse or per return of ready.
    always @(negedge clk) begin
        exp_t want;
        if (dup && reject) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL dup_reject_overlap: got both high, wanted at most one");
        end
        if (!nRst) begin
            last_flush = 1'b1;
        end else if (reject || (ready && !prev_ready && !last_flush)) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_response: got reject=%0b ready=%0b, wanted no response", reject, ready);
            end else begin
                want = exp_q.pop_front();
                checkOutput("resp_kind_reject", RW'(reject), RW'(want.is_reject));
                checkOutput("resp_dup",         RW'(dup),    RW'(want.exp_dup));
                checkOutput("resp_ready",       RW'(ready),  RW'(1));
                checkOutput("resp_latency",     RW'(edge_cnt - want.accept_edge), RW'(want.lat));
                checkOutput("resp_row1",        row1,        want.r1);
                checkOutput("resp_row2",        row2,        want.r2);
                checkOutput("resp_count",       RW'(count),  RW'(want.cnt));
                checkOutput("resp_full",        RW'(full),   RW'(want.cnt == SLOTS));
            end
            last_flush = clear;
        end else begin
            if (dup) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL stray_dup: got dup=1, wanted 0");
            end
            last_flush = clear;
        end
        prev_ready = ready;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, wanted completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
        @(posedge clk); #1;
        checkState("reset");

        applyStimulus("h");
        applyStimulus("A");
        drain();
        checkState("ha");
        applyStimulus("a");
        drain();
        checkState("dup_a");
        applyStimulus("3");
        applyStimulus(8'h20);
        drain();
        checkState("rejects");

        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        resetModel();
        checkState("clear_idle");
        for (int i = 0; i < 10; i++) applyStimulus(8'h41 + 8'(i));
        drain();
        checkState("filled");
        applyStimulus("K");
        drain();
        checkState("overflow");

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      applyStimulus(8'($urandom_range(0, 255)));
            else if (r < 6) applyStimulus(8'h41 + 8'($urandom_range(0, 13)));
            else            applyStimulus(8'h61 + 8'($urandom_range(0, 13)));
        end
        drain();
        checkState("random_end");

        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        resetModel();
        for (int i = 0; i < 5; i++) applyStimulus(8'h4C + 8'(i));
        drain();
        applyStimulus("z");
        @(posedge clk); #1;
        clear = 1'b1;
        exp_q.delete();
        resetModel();
        @(posedge clk); #1;
        clear = 1'b0;
        checkState("clear_mid_scan");
        repeat (8) @(posedge clk);
        #1 checkState("clear_settled");

        for (int i = 0; i < 5; i++) applyStimulus(8'h50 + 8'(i));
        drain();
        applyStimulus("y");
        @(posedge clk); #1;
        nRst = 1'b0;
        exp_q.delete();
        resetModel();
        #2 checkState("nrst_mid_scan");
        #4 nRst = 1'b1;
        @(posedge clk); #1;
        checkState("nrst_released");

        valid  = 1'b1;
        letter = "q";
        clear  = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkState("clear_with_valid");

        applyStimulus("B");
        drain();
        checkState("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
